// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter measurement sequencer.
package freq_meter_pkg;

  localparam int N_SAMPLES_DEF = 4;
  localparam int TIMEOUT_DEF   = 1 << 20;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LAUNCH = 5'b00010,
    RUN    = 5'b00100,
    ACCUM  = 5'b01000,
    DONE   = 5'b10000
  } mctrl_state_t;

endpackage

// File: rtl/measure_ctrl_timer.sv
// RUN-state watchdog: counts enabled cycles from a clear and flags the last allowed cycle.
module timeout_timer
  import freq_meter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(LIMIT - 1));

  // Saturates on the last cycle so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/measure_ctrl.sv
// Sequences N_SAMPLES pulse-width measurements on the Counter and accumulates sum/min/max/avg,
// aborting a run with err when one measurement stays busy past TIMEOUT cycles.
module measure_ctrl
  import freq_meter_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int VAL_W     = 32,
  parameter int SUM_W     = VAL_W + $clog2(N_SAMPLES),
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           cnt_start,
  input  logic                           cnt_busy,
  input  logic [VAL_W-1:0]               cnt_val,
  output logic [SUM_W-1:0]               sum,
  output logic [VAL_W-1:0]               avg,
  output logic [VAL_W-1:0]               min_val,
  output logic [VAL_W-1:0]               max_val,
  output logic [$clog2(N_SAMPLES+1)-1:0] n_done
);

  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int NW    = $clog2(N_SAMPLES + 1);

  mctrl_state_t   state;
  logic           run_first;
  logic           expired;
  logic [SUM_W-1:0] sum_nxt;
  logic [SUM_W-1:0] avg_full;

  timeout_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_start),
    .en      (state == RUN),
    .expired (expired)
  );

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    // Never start the Counter while a stale (timed-out) run is still finishing.
    cnt_start = (state == LAUNCH) && !cnt_busy;
    sum_nxt   = sum + SUM_W'(cnt_val);
    avg_full  = sum_nxt >> LOG2N;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_first <= 1'b0;
      err       <= 1'b0;
      sum       <= '0;
      avg       <= '0;
      min_val   <= '1;
      max_val   <= '0;
      n_done    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            err     <= 1'b0;
            sum     <= '0;
            avg     <= '0;
            min_val <= '1;
            max_val <= '0;
            n_done  <= '0;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!cnt_busy) begin
            run_first <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          run_first <= 1'b0;
          // The Counter registers start, so busy is only meaningful from the second RUN cycle.
          if (!run_first && !cnt_busy) begin
            sum    <= sum_nxt;
            avg    <= avg_full[VAL_W-1:0];
            if (cnt_val <= min_val) min_val <= cnt_val;
            if (cnt_val >= max_val) max_val <= cnt_val;
            n_done <= n_done + 1'b1;
            state  <= ACCUM;
          end else if (expired && cnt_busy) begin
            err   <= 1'b1;
            state <= DONE;
          end
        end
        ACCUM: begin
          state <= (n_done == NW'(N_SAMPLES)) ? DONE : LAUNCH;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_measure_ctrl.sv
// Randomized bench for measure_ctrl: a behavioural Counter model logs every delivered sample,
// and each run's results are recomputed from that log with plain arithmetic.
module tb_measure_ctrl;

  localparam int N  = 4;
  localparam int VW = 32;
  localparam int SW = 34;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          busy, done, err, cnt_start;
  logic          cnt_busy = 1'b0;
  logic [VW-1:0] cnt_val = '0;
  logic [SW-1:0] sum;
  logic [VW-1:0] avg, min_val, max_val;
  logic [2:0]    n_done;

  measure_ctrl #(.N_SAMPLES(N), .VAL_W(VW), .SUM_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .done(done), .err(err),
    .cnt_start(cnt_start), .cnt_busy(cnt_busy), .cnt_val(cnt_val),
    .sum(sum), .avg(avg), .min_val(min_val), .max_val(max_val), .n_done(n_done)
  );

  always #5 clk = ~clk;

  // Knobs, written only by the stimulus process
  int          base_start = 0;
  int          hang_at    = -1;
  int          dur_max    = 8;
  bit          rel        = 1'b0;
  bit          use_tbl    = 1'b0;
  bit          rmode      = 1'b0;
  logic [31:0] tbl [4];

  // Counter model and monitors
  int          cyc = 0, nstart = 0, ncomp = 0, ndone = 0, bad_start = 0, last_start = 0;
  int          left = 0;
  bit          hold = 1'b0;
  logic [31:0] nxt_val = '0;
  logic [31:0] log_v [1024];

  function automatic logic [31:0] pick(input int k);
    if (use_tbl) return tbl[k & 3];
    if (rmode)   return 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) ndone <= ndone + 1;
    if (cnt_start && cnt_busy) bad_start <= bad_start + 1;
    if (cnt_start) begin
      last_start <= cyc;
      nstart     <= nstart + 1;
      cnt_busy   <= 1'b1;
      hold       <= ((nstart - base_start) == hang_at);
      left       <= int'($urandom_range(0, dur_max));
      nxt_val    <= pick(nstart - base_start);
    end else if (cnt_busy) begin
      if (hold) begin
        if (rel) hold <= 1'b0;
      end else if (left == 0) begin
        cnt_busy            <= 1'b0;
        cnt_val             <= nxt_val;
        log_v[ncomp % 1024] <= nxt_val;
        ncomp               <= ncomp + 1;
      end else begin
        left <= left - 1;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_start"}, cnt_start, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_avg"}, avg, 0);
    chk({tag, "_min"}, min_val, 32'hFFFF_FFFF);
    chk({tag, "_max"}, max_val, 0);
    chk({tag, "_n"}, n_done, 0);
  endtask

  // One request; hang = sample index that never finishes (-1: none), spam = stray reqs,
  // kill = assert reset once this many samples have completed (-1: never).
  task automatic run_req(input int hang, input bit spam, input int kill);
    int c0, nd0, to, cnt;
    longint unsigned s, mn, mx;
    base_start = nstart;
    hang_at    = hang;
    rel        = 1'b0;
    nd0        = ndone;
    req = 1'b1; tick(); req = 1'b0;
    to = 0;
    while (!cnt_start && to < 5000) begin tick(); to++; end
    chk("start_seen", cnt_start, 1);
    c0 = ncomp;
    to = 0;
    while (!done && to < 5000) begin
      if (kill >= 0 && (ncomp - c0) >= kill && cnt_busy) begin
        rst_n = 1'b0; req = 1'b0;
        tick();
        chk_reset("midrun_rst");
        chk("no_done_on_rst", ndone - nd0, 0);
        rst_n = 1'b1;
        tick();
        return;
      end
      req = spam && ($urandom_range(0, 3) == 0);
      tick(); to++;
    end
    req = 1'b0;
    chk("done_seen", done, 1);
    cnt = ncomp - c0;
    s = 0; mn = 64'hFFFF_FFFF; mx = 0;
    for (int i = 0; i < cnt; i++) begin
      longint unsigned v = log_v[(c0 + i) % 1024];
      s += v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    chk("sum", sum, s);
    chk("avg", avg, (s >> 2) & 64'hFFFF_FFFF);
    chk("min", min_val, mn);
    chk("max", max_val, mx);
    chk("n_done", n_done, (hang >= 0) ? hang : N);
    chk("err", err, (hang >= 0) ? 1 : 0);
    chk("busy_at_done", busy, 1);
    if (hang >= 0) chk("timeout_latency", cyc - last_start, TO + 1);
    req = 1'b1; tick(); req = 1'b0;
    chk("req_in_done_ignored", busy, 0);
    tick();
    chk("one_done", ndone - nd0, 1);
    if (hang >= 0) begin
      repeat (10) tick();
      rel = 1'b1;
      tick();
    end
  endtask

  initial begin
    tbl[0] = 32'd10; tbl[1] = 32'd20; tbl[2] = 32'd30; tbl[3] = 32'd40;
    repeat (3) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Fixed table 10..40
    use_tbl = 1'b1; dur_max = 6;
    run_req(-1, 1'b0, -1);
    chk("t1_sum", sum, 100);
    chk("t1_avg", avg, 25);
    chk("t1_min", min_val, 10);
    chk("t1_max", max_val, 40);

    // Dead wave on the first sample, then recovery while the stale run drains
    use_tbl = 1'b0; dur_max = 30;
    run_req(0, 1'b0, -1);
    chk("t2_min_untouched", min_val, 32'hFFFF_FFFF);
    run_req(-1, 1'b0, -1);

    // Stray requests while running
    dur_max = 12;
    run_req(-1, 1'b1, -1);

    // Reset during the third sample, then a fresh run
    run_req(-1, 1'b0, 2);
    run_req(-1, 1'b0, -1);

    // Timeout after two good samples keeps them
    run_req(2, 1'b0, -1);

    // Ties and the widest values
    use_tbl = 1'b1;
    for (int i = 0; i < 4; i++) tbl[i] = 32'd7;
    run_req(-1, 1'b0, -1);
    chk("t6_sum7", sum, 28);
    chk("t6_avg7", avg, 7);
    for (int i = 0; i < 4; i++) tbl[i] = 32'hFFFF_FFFF;
    run_req(-1, 1'b0, -1);
    chk("t6_sum_max", sum, 64'd4 * 64'hFFFF_FFFF);
    chk("t6_avg_max", avg, 32'hFFFF_FFFF);

    // Random runs
    use_tbl = 1'b0;
    for (int r = 0; r < 15; r++) begin
      rmode   = bit'($urandom_range(0, 1));
      dur_max = int'($urandom_range(0, 20));
      run_req(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
              bit'($urandom_range(0, 1)), -1);
    end

    chk("start_while_busy", bad_start, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
